// File: rtl/led_scanner_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// led_scanner_ctrl_pkg
//
// Shared definitions for the ping-pong LED scanner:
//   - LED_W / LED_RESET      : width of the LED bank and its power-on pattern
//   - LED_TOP_BOUNCE         : pattern loaded when the lit LED reverses at bit 15
//   - LED_BOT_BOUNCE         : pattern loaded when the lit LED reverses at bit 0
//   - dir_e (DIR_UP/DIR_DOWN): scan direction (UP = toward bit 15)
//   - HOLD_CYCLES_DEFAULT    : default auto-repeat interval in held cycles
//   - is_onehot()            : helper used to detect a corrupted LED register
// -----------------------------------------------------------------------------
package led_scanner_ctrl_pkg;

  localparam int unsigned LED_W = 16;

  localparam logic [LED_W-1:0] LED_RESET      = 16'h0001;
  localparam logic [LED_W-1:0] LED_TOP_BOUNCE = 16'h4000;
  localparam logic [LED_W-1:0] LED_BOT_BOUNCE = 16'h0002;

  localparam int unsigned HOLD_CYCLES_DEFAULT = 8;

  typedef enum logic {
    DIR_UP   = 1'b0,  // moving toward bit 15
    DIR_DOWN = 1'b1   // moving toward bit 0
  } dir_e;

  // True when exactly one bit of v is set. Clearing the lowest set bit
  // (v & (v-1)) leaves zero only for a power of two.
  function automatic logic is_onehot(input logic [LED_W-1:0] v);
    return (v != '0) && ((v & (v - 1'b1)) == '0);
  endfunction

endpackage : led_scanner_ctrl_pkg

// File: rtl/led_scanner_ctrl_btn_step_gen.sv
// -----------------------------------------------------------------------------
// btn_step_gen
//
// Turns a debounced button level into single-cycle step requests:
//   - a rising edge of the button requests a step immediately;
//   - while the button stays high, a further step is requested every
//     HOLD_CYCLES cycles (auto-repeat);
//   - releasing the button clears the hold counter.
//
// The step output is combinational from the current button level and the
// registered history, so a press sampled at edge N can update the LED
// register at that same edge N.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset
//   button in   debounced button level
//   step   out  one-cycle step request (valid for the upcoming edge)
// -----------------------------------------------------------------------------
module btn_step_gen
  import led_scanner_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic button,
  output logic step
);

  localparam int unsigned CNT_W = $clog2(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(HOLD_CYCLES - 1);

  logic             btn_q, btn_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press;
  logic             held;

  always_comb begin
    // btn_q is cleared by reset, so a button already high when reset
    // releases is seen as a fresh press on the first free-running edge.
    press = button & ~btn_q;
    held  = button &  btn_q;

    btn_d = button;
    cnt_d = cnt_q;
    step  = 1'b0;

    if (press) begin
      step  = 1'b1;
      cnt_d = '0;
    end else if (held) begin
      if (cnt_q == CNT_MAX) begin
        step  = 1'b1;
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      btn_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      btn_q <= btn_d;
      cnt_q <= cnt_d;
    end
  end

endmodule : btn_step_gen

// File: rtl/led_scanner_ctrl.sv
// -----------------------------------------------------------------------------
// led_scanner_ctrl
//
// Single-lit 16-LED ping-pong scanner. Each step request from btn_step_gen
// moves the lit LED one place; at bit 15 or bit 0 the direction reverses and
// the LED moves straight back toward the middle, so the end LEDs are lit for
// one step only (30-step period).
//
// If the LED register is ever found not to be one-hot (e.g. after an upset),
// the next edge restores the reset pattern and upward direction.
//
// Ports:
//   clk    in   system clock, rising edge
//   reset  in   synchronous active-high reset (priority over button)
//   button in   debounced button level
//   led    out  registered one-hot LED pattern [15:0]
// -----------------------------------------------------------------------------
module led_scanner_ctrl
  import led_scanner_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = HOLD_CYCLES_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        button,
  output logic [15:0] led
);

  logic [LED_W-1:0] led_q, led_d;
  dir_e             dir_q, dir_d;
  logic             step;

  btn_step_gen #(
    .HOLD_CYCLES (HOLD_CYCLES)
  ) u_step_gen (
    .clk    (clk),
    .reset  (reset),
    .button (button),
    .step   (step)
  );

  always_comb begin
    led_d = led_q;
    dir_d = dir_q;

    if (!is_onehot(led_q)) begin
      // Corrupted pattern: recover regardless of any pending step.
      led_d = LED_RESET;
      dir_d = DIR_UP;
    end else if (step) begin
      if (dir_q == DIR_UP) begin
        if (led_q[LED_W-1]) begin
          dir_d = DIR_DOWN;
          led_d = LED_TOP_BOUNCE;
        end else begin
          led_d = led_q << 1;
        end
      end else begin
        if (led_q[0]) begin
          dir_d = DIR_UP;
          led_d = LED_BOT_BOUNCE;
        end else begin
          led_d = led_q >> 1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      led_q <= LED_RESET;
      dir_q <= DIR_UP;
    end else begin
      led_q <= led_d;
      dir_q <= dir_d;
    end
  end

  assign led = led_q;

endmodule : led_scanner_ctrl

// File: tb/tb_led_scanner_ctrl.sv
// -----------------------------------------------------------------------------
// tb_led_scanner_ctrl
//
// Driver applies reset/button at the falling edge and pushes the LED value
// expected after the following rising edge into a scoreboard queue. The
// reference model tracks the position in the 30-step bounce sequence and the
// length of the current button-high run; a step happens when the run length
// is 1, 1+H, 1+2H, ... A monitor pops and compares 1 time unit after each
// rising edge.
// -----------------------------------------------------------------------------
module tb_led_scanner_ctrl;

  localparam int H = 8;

  logic        clk;
  logic        reset;
  logic        button;
  logic [15:0] led;

  int checks   = 0;
  int failures = 0;
  int txn      = 0;

  // Scoreboard entries: expected LED pattern plus a tag for messages.
  logic [15:0] exp_q[$];
  int          tag_q[$];

  // Reference model state.
  int pos = 0;   // 0..29 along the bounce sequence
  int run = 0;   // consecutive high samples since last low/reset

  led_scanner_ctrl #(.HOLD_CYCLES(H)) dut (
    .clk    (clk),
    .reset  (reset),
    .button (button),
    .led    (led)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] pos_to_led(input int p);
    int bitn;
    bitn = (p < 16) ? p : 30 - p;
    return 16'(32'd1 << bitn);
  endfunction

  task automatic cycle(input logic r, input logic b);
    @(negedge clk);
    reset  = r;
    button = b;
    if (r) begin
      pos = 0;
      run = 0;
    end else begin
      run = b ? run + 1 : 0;
      if (b && ((run - 1) % H == 0))
        pos = (pos + 1) % 30;
    end
    exp_q.push_back(pos_to_led(pos));
    tag_q.push_back(txn);
    txn++;
  endtask

  task automatic pulse();
    cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
  endtask

  // Monitor: compare one queued expectation per rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        logic [15:0] e;
        int          t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        if (led !== e) begin
          failures++;
          $display("FAIL led txn=%0d reset=%0b button=%0b got=%h expected=%h",
                   t, reset, button, led, e);
        end else begin
          $display("txn=%0d reset=%0b button=%0b led=%h ok", t, reset, button, led);
        end
      end
    end
  end

  initial begin
    reset  = 1'b1;
    button = 1'b0;

    // Reset held 5 cycles, then idle low.
    repeat (5) cycle(1'b1, 1'b0);
    repeat (10) cycle(1'b0, 1'b0);

    // Three isolated pulses: 0002, 0004, 0008.
    repeat (3) pulse();

    // Full bounce: 15 pulses to 8000, reversal, 14 more to 0001, then 0002.
    cycle(1'b1, 1'b0);
    repeat (15) pulse();
    pulse();
    repeat (14) pulse();
    pulse();

    // Continuous hold of 20 cycles from 0001.
    cycle(1'b1, 1'b0);
    repeat (20) cycle(1'b0, 1'b1);
    repeat (3) cycle(1'b0, 1'b0);

    // Release and re-press inside a hold window.
    repeat (5) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);
    repeat (12) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);

    // Reach 0100, then reset with button held, release with button high.
    cycle(1'b1, 1'b0);
    repeat (8) pulse();
    repeat (3) cycle(1'b1, 1'b1);
    repeat (3) cycle(1'b0, 1'b1);
    cycle(1'b0, 1'b0);

    // Randomized: sticky button level with occasional resets.
    for (int i = 0; i < 2000; i++) begin
      logic b, r;
      b = ($urandom_range(0, 99) < 80) ? button : ~button;
      r = ($urandom_range(0, 199) == 0);
      cycle(r, b);
    end
    cycle(1'b0, 1'b0);

    // Drain the scoreboard with a bounded wait.
    for (int k = 0; k < 10 && exp_q.size() > 0; k++)
      @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d required=0", exp_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_led_scanner_ctrl

// File: doc/led_scanner_ctrl.md
Name: led_scanner_ctrl

Overview:
- Single-lit 16-LED "ping-pong" scanner driven by one push button.
- Each new button press moves the lit LED one position. Holding the button auto-repeats the step.
- The lit LED bounces between bit 0 and bit 15.
- Top-level board block, direct drive of the 16 board LEDs. The button is already synchronised and debounced upstream.

Parameters:
- HOLD_CYCLES, 8, consecutive held cycles between auto-repeat steps. Must be at least 2.

Ports:
- clk, input, 1, system clock. All state updates on the rising edge.
- reset, input, 1, synchronous, active-high reset.
- button, input, 1, level from the debounced push button.
- led, output, 16, one-hot LED pattern. Registered.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (ports clk, reset).
- Registers: led[15:0], dir (0 = moving toward bit 15, 1 = toward bit 0), btn_q (previous button sample), hold counter cnt, sized $clog2(HOLD_CYCLES).
- Reset values: led = 16'h0001, dir = 0, btn_q = 0, cnt = 0.
  - Reset has priority over button.
  - Reset asserted mid-operation returns to these values on the next edge.
- btn_q <= button every non-reset cycle.
- press = button & ~btn_q. Because btn_q is cleared by reset, a button held high through reset release counts as a press on the first non-reset edge.
- Step generation, evaluated at each rising edge:
  - press: step; cnt <= 0.
  - button & btn_q (held) and cnt == HOLD_CYCLES-1: step; cnt <= 0.
  - held and cnt < HOLD_CYCLES-1: cnt <= cnt+1, no step.
  - button low: cnt <= 0, no step.
- Continuous hold therefore steps on the press edge, then every HOLD_CYCLES cycles.
- Step with dir = 0:
  - if led[15]: dir <= 1, led <= 16'h4000;
  - else led <= led << 1.
- Step with dir = 1:
  - if led[0]: dir <= 0, led <= 16'h0002;
  - else led <= led >> 1.
- Full period is 30 steps: 0x0001, 0x0002, …, 0x8000, 0x4000, …, 0x0001, 0x0002, …
- Latency: button sampled at edge N changes led at edge N. The new value is visible after that edge; no combinational path from button to led.
- led is always exactly one-hot.
- Recovery rule: if a non-one-hot led value is ever detected, the next edge forces led = 16'h0001, dir = 0.

Decomposition:
- Shared package: LED_RESET = 16'h0001, the direction encodings DIR_UP/DIR_DOWN, default HOLD_CYCLES.
- Sub-module btn_step_gen: edge detect plus hold counter, producing a 1-cycle step pulse.
- Top: direction/shift register logic.

Test Plan:
- Reset held 5 cycles, button = 0 -> led = 0001 after reset and throughout; no change with button low for 10 cycles.
- Pulse button high 1 cycle, then low 1 cycle, repeated 3 times -> led 0002, 0004, 0008, one step per pulse, no extra steps.
- 15 isolated pulses from reset -> led = 8000. Next pulse -> 4000 (reversal). 14 more pulses -> 0001. Next pulse -> 0002.
- From led = 0001, hold button high for 20 cycles (HOLD_CYCLES = 8):
  - press edge -> 0002;
  - edge +8 -> 0004;
  - edge +16 -> 0008;
  - no other changes.
- Release and re-press during a hold window -> cnt restarts: immediate step on the new press, next auto step 8 cycles later.
- Assert reset while led = 0100 with button held, then release with button still high -> led = 0001 during reset; 0002 on the first edge after release (press detected).
